mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 rst  input  1  reset rst, synchronous, active-high.
REQ-003 mem_req_i  input  1  memory-stage load/store request.
REQ-004 mem_we_i  input  1  1 = store, 0 = load.
REQ-005 mem_size_i  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-006 mem_signed_i  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-007 mem_addr_i  input  32  byte address.
REQ-008 mem_wdata_i  input  32  store data, right-justified.
REQ-009 rdata_o  output  32  extended load result; valid while done_o=1.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 stall_o  output  1  holds the pipeline while an access is outstanding.
REQ-012 adel_o / ades_o  output  1 each  misaligned load / misaligned store.
REQ-013 bus_err_o  output  1  timeout flag; valid with done_o.
REQ-014 bus_req_o, bus_we_o  output  1 each  bus request and write strobe.
REQ-015 bus_sel_o  output  4  byte lanes; bit n = byte addr[1:0]==n (little-endian).
REQ-016 bus_addr_o, bus_wdata_o  output  32 each  word-aligned address ({addr[31:2],2'b00}), lane-replicated write data.
REQ-017 bus_ack_i  input  1, bus_rdata_i  input  32  bus acknowledge and read word.

Function
REQ-018 FSM states: IDLE, REQ, DONE.
REQ-019 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=00, byte always aligned.
REQ-020 IDLE with mem_req_i=1 and misaligned: adel_o (load) or ades_o (store) =1 combinationally that cycle; no bus access; stall_o=0; stay IDLE.
REQ-021 IDLE with mem_req_i=1 and aligned: stall_o=1 combinationally; at the edge, latch we/size/signed/addr/wdata, go to REQ, clear timeout counter.
REQ-022 REQ: bus_req_o=1, stall_o=1, bus outputs driven from latched values only; mem_* inputs are ignored.
REQ-023 bus_sel_o: byte 0001<<addr[1:0]; halfword 0011<<addr[1:0]; word 1111.
REQ-024 bus_wdata_o: byte {4{wdata[7:0]}}, halfword {2{wdata[15:0]}}, word wdata.
REQ-025 REQ with bus_ack_i=1: at the edge, capture bus_rdata_i and go to DONE; the minimum latency from request to done_o is 2 cycles.
REQ-026 REQ timeout: 4-bit counter increments each REQ cycle without ack; ack absent for 16 REQ cycles -> DONE with bus_err_o=1 and rdata_o=0.
REQ-027 DONE: done_o=1, stall_o=0, bus_req_o=0; the next state is always IDLE; the pipeline advances at this edge.
REQ-028 Load extraction: select byte/halfword by latched addr[1:0] from captured word; extend per latched signed; store completions drive rdata_o=0.
REQ-029 rdata_o and bus_err_o are 0 outside DONE.
REQ-030 An ack arriving in IDLE or DONE is ignored.

Reset
REQ-031 rst=1 at an edge forces IDLE from any state, including mid-REQ, and clears latched fields and the counter.
REQ-032 During reset and in the following IDLE, all outputs are 0.
REQ-033 An outstanding bus access aborted by reset is not retried.

Verification
REQ-034 LB signed, addr 0x1003, bus_rdata 0x80FFFFFF, ack in the 1st REQ cycle -> sel 1000, done_o in cycle 2, rdata_o 0xFFFFFF80.
REQ-035 SH, addr 0x2002, wdata 0x0000ABCD -> bus_sel 1100, bus_wdata 0xABCDABCD, bus_we 1, stall_o 1 until DONE.
REQ-036 LW, addr 0x3001 -> adel_o=1 for that cycle, bus_req_o never asserted, stall_o 0.
REQ-037 LHU, addr 0x4000, no ack -> after 16 REQ cycles done_o=1, bus_err_o=1, rdata_o 0, then IDLE.
REQ-038 LW in REQ, rst pulsed for one cycle, then ack -> next cycle IDLE, bus_req_o 0, no done_o.
REQ-039 Back-to-back SW then LW, ack delayed 3 cycles each -> two done_o pulses, stall_o low only in each DONE cycle.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: turns one memory-stage load/store into a single bus transaction.
// It checks alignment, builds the byte lanes and the replicated write data,
// waits for the bus acknowledge (or gives up after a timeout), and returns
// the extended load result in a one-cycle completion pulse.
//
// Handshakes:
//   pipeline side: the memory stage holds mem_req_i and its operands while
//   stall_o=1. A request is accepted in the IDLE cycle where stall_o first
//   rises. Completion is the single cycle where done_o=1, and the pipeline
//   advances at the end of that cycle.
//   bus side: bus_req_o stays high, with constant address, lanes and data,
//   until the cycle in which bus_ack_i=1 is sampled. That cycle transfers
//   the read word. An ack seen while bus_req_o=0 carries no meaning.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Access fields latched at acceptance; the bus only ever sees these.
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [3:0]  tmo_cnt;
  logic [31:0] cap_rdata;
  logic        cap_err;

  logic        in_aligned;
  logic        accept;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] shifted_b;
  logic [31:0] shifted_h;
  logic [31:0] load_data;

  // Alignment of the incoming request; size 11 is handled as a word.
  always_comb begin
    in_aligned = 1'b1;
    case (mem_size_i)
      2'b00:   in_aligned = 1'b1;
      2'b01:   in_aligned = ~mem_addr_i[0];
      default: in_aligned = (mem_addr_i[1:0] == 2'b00);
    endcase
  end

  assign accept = (state == S_IDLE) && mem_req_i && in_aligned;

  // Byte lanes and lane-replicated store data from the latched access.
  always_comb begin
    lane_sel   = 4'b1111;
    lane_wdata = lat_wdata;
    case (lat_size)
      2'b00: begin
        lane_sel   = 4'b0001 << lat_addr[1:0];
        lane_wdata = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        lane_sel   = 4'b0011 << lat_addr[1:0];
        lane_wdata = {2{lat_wdata[15:0]}};
      end
      default: begin
        lane_sel   = 4'b1111;
        lane_wdata = lat_wdata;
      end
    endcase
  end

  // Load extraction: pick the addressed byte/halfword and extend it.
  // A timed-out access has an all-zero captured word, so it yields 0 too.
  always_comb begin
    shifted_b = cap_rdata >> {lat_addr[1:0], 3'b000};
    shifted_h = cap_rdata >> {lat_addr[1], 4'b0000};
    load_data = cap_rdata;
    case (lat_size)
      2'b00:   load_data = lat_signed ? {{24{shifted_b[7]}}, shifted_b[7:0]}
                                      : {24'd0, shifted_b[7:0]};
      2'b01:   load_data = lat_signed ? {{16{shifted_h[15]}}, shifted_h[15:0]}
                                      : {16'd0, shifted_h[15:0]};
      default: load_data = cap_rdata;
    endcase
    if (lat_we || cap_err) begin
      load_data = 32'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and all outputs; everything is held at 0 during reset.
  always_comb begin
    state_next  = state;
    rdata_o     = 32'd0;
    done_o      = 1'b0;
    stall_o     = 1'b0;
    adel_o      = 1'b0;
    ades_o      = 1'b0;
    bus_err_o   = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_sel_o   = 4'd0;
    bus_addr_o  = 32'd0;
    bus_wdata_o = 32'd0;
    case (state)
      S_IDLE: begin
        if (mem_req_i) begin
          if (in_aligned) begin
            stall_o    = 1'b1;
            state_next = S_REQ;
          end else begin
            adel_o = ~mem_we_i;
            ades_o = mem_we_i;
          end
        end
      end
      S_REQ: begin
        stall_o     = 1'b1;
        bus_req_o   = 1'b1;
        bus_we_o    = lat_we;
        bus_sel_o   = lane_sel;
        bus_addr_o  = {lat_addr[31:2], 2'b00};
        bus_wdata_o = lane_wdata;
        if (bus_ack_i || (tmo_cnt == 4'hF)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_o     = 1'b1;
        rdata_o    = load_data;
        bus_err_o  = cap_err;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (rst) begin
      rdata_o     = 32'd0;
      done_o      = 1'b0;
      stall_o     = 1'b0;
      adel_o      = 1'b0;
      ades_o      = 1'b0;
      bus_err_o   = 1'b0;
      bus_req_o   = 1'b0;
      bus_we_o    = 1'b0;
      bus_sel_o   = 4'd0;
      bus_addr_o  = 32'd0;
      bus_wdata_o = 32'd0;
    end
  end

  assign dbg_state = rst ? 2'b00 : state;

  // Datapath: latch the access, count unacknowledged REQ cycles, capture the
  // read word or the timeout result.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_size   <= 2'd0;
      lat_signed <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      tmo_cnt    <= 4'd0;
      cap_rdata  <= 32'd0;
      cap_err    <= 1'b0;
    end else if (accept) begin
      lat_we     <= mem_we_i;
      lat_size   <= mem_size_i;
      lat_signed <= mem_signed_i;
      lat_addr   <= mem_addr_i;
      lat_wdata  <= mem_wdata_i;
      tmo_cnt    <= 4'd0;
      cap_rdata  <= 32'd0;
      cap_err    <= 1'b0;
    end else if (state == S_REQ) begin
      if (bus_ack_i) begin
        cap_rdata <= bus_rdata_i;
        cap_err   <= 1'b0;
      end else if (tmo_cnt == 4'hF) begin
        cap_rdata <= 32'd0;
        cap_err   <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized accesses against a small
// arithmetic reference model of the memory controller.
module tb_mem_ctrl;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        mem_req_i, mem_we_i, mem_signed_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [31:0] rdata_o;
  logic        done_o, stall_o, adel_o, ades_o, bus_err_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_signed_i(mem_signed_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .rdata_o(rdata_o), .done_o(done_o), .stall_o(stall_o),
    .adel_o(adel_o), .ades_o(ades_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .dbg_state(dbg_state)
  );

  // Scoreboard checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
  endfunction

  function automatic bit m_aligned(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) == 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [31:0] addr);
    int n = nbytes(size);
    int off = (n == 4) ? 0 : int'(addr % 4);
    int mask = ((1 << n) - 1) << off;
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wdata);
    int n = nbytes(size);
    if (n == 1) return (wdata & 32'hFF) * 32'h01010101;
    if (n == 2) return (wdata & 32'hFFFF) * 32'h00010001;
    return wdata;
  endfunction

  function automatic logic [31:0] m_rdata(input logic we, input logic [1:0] size, input logic sgn,
                                          input logic [31:0] addr, input logic [31:0] word,
                                          input bit err);
    int n = nbytes(size);
    int off = (n == 4) ? 0 : int'(addr % 4);
    longint v;
    if (we || err) return 32'd0;
    v = (longint'(word) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // Driver tasks
  task automatic scramble_mem;
    mem_req_i    = 1'($urandom);
    mem_we_i     = 1'($urandom);
    mem_size_i   = 2'($urandom);
    mem_signed_i = 1'($urandom);
    mem_addr_i   = $urandom;
    mem_wdata_i  = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk1({tag, "_done"}, done_o, 1'b0);
    chk1({tag, "_stall"}, stall_o, 1'b0);
    chk1({tag, "_adel"}, adel_o, 1'b0);
    chk1({tag, "_ades"}, ades_o, 1'b0);
    chk1({tag, "_err"}, bus_err_o, 1'b0);
    chk1({tag, "_bus_req"}, bus_req_o, 1'b0);
    chk1({tag, "_bus_we"}, bus_we_o, 1'b0);
    chk({tag, "_sel"}, 32'(bus_sel_o), 32'd0);
    chk({tag, "_addr"}, bus_addr_o, 32'd0);
    chk({tag, "_wdata"}, bus_wdata_o, 32'd0);
  endtask

  // One aligned access; delay > 15 means the bus never acknowledges.
  task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [31:0] word);
    bit acked = 0;
    bit err = (delay > 15);
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_signed_i = sgn;
    mem_addr_i = addr; mem_wdata_i = wdata;
    bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
    #1;
    chk1("issue_stall", stall_o, 1'b1);
    chk1("issue_bus_req", bus_req_o, 1'b0);
    chk1("issue_adel", adel_o, 1'b0);
    chk1("issue_ades", ades_o, 1'b0);
    chk1("issue_done", done_o, 1'b0);
    tick;
    for (int k = 0; k < 16 && !acked; k++) begin
      scramble_mem;
      bus_ack_i   = (k == delay);
      bus_rdata_i = (k == delay) ? word : $urandom;
      #1;
      chk1("req_bus_req", bus_req_o, 1'b1);
      chk1("req_stall", stall_o, 1'b1);
      chk1("req_done", done_o, 1'b0);
      chk1("req_we", bus_we_o, we);
      chk("req_sel", 32'(bus_sel_o), 32'(m_sel(size, addr)));
      chk("req_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
      chk("req_wdata", bus_wdata_o, m_wdata(size, wdata));
      chk("req_rdata", rdata_o, 32'd0);
      chk1("req_err", bus_err_o, 1'b0);
      tick;
      acked = (k == delay);
    end
    scramble_mem;
    bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
    #1;
    chk1("done_pulse", done_o, 1'b1);
    chk1("done_stall", stall_o, 1'b0);
    chk1("done_bus_req", bus_req_o, 1'b0);
    chk1("done_adel", adel_o, 1'b0);
    chk1("done_ades", ades_o, 1'b0);
    chk1("done_err", bus_err_o, err);
    chk("done_rdata", rdata_o, m_rdata(we, size, sgn, addr, word, err));
    tick;
    mem_req_i = 1'b0;
    bus_ack_i = 1'b0;
  endtask

  task automatic do_misaligned(input logic we, input logic [1:0] size, input logic [31:0] addr);
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_signed_i = 1'($urandom);
    mem_addr_i = addr; mem_wdata_i = $urandom;
    bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
    #1;
    chk1("mis_adel", adel_o, ~we);
    chk1("mis_ades", ades_o, we);
    chk1("mis_stall", stall_o, 1'b0);
    chk1("mis_bus_req", bus_req_o, 1'b0);
    chk1("mis_done", done_o, 1'b0);
    tick;
    mem_req_i = 1'b0;
    bus_ack_i = 1'b0;
    #1;
    chk_all_zero("mis_after");
    tick;
  endtask

  initial begin
    logic [1:0]  size;
    logic [31:0] addr;
    int          delay;

    // Reset with a request pending: everything stays quiet.
    rst = 1'b1;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'd2; mem_signed_i = 1'b0;
    mem_addr_i = 32'h100; mem_wdata_i = 32'h0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    #1;
    chk_all_zero("in_reset");
    tick;
    tick;
    rst = 1'b0;
    mem_req_i = 1'b0; bus_ack_i = 1'b1;
    #1;
    chk_all_zero("post_reset");
    tick;
    bus_ack_i = 1'b0;

    // LB signed from the top byte lane, ack in the first REQ cycle.
    do_access(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 0, 32'h80FF_FFFF);
    // SH to the upper halfword, ack after two wait cycles.
    do_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 2, 32'h1234_5678);
    // Misaligned LW.
    do_misaligned(1'b0, 2'd2, 32'h3001);
    // LHU that never gets an ack.
    do_access(1'b0, 2'd1, 1'b0, 32'h4000, 32'h0, 16, 32'h0);
    #1;
    chk_all_zero("after_timeout");
    tick;

    // Reset in the middle of a REQ; the late ack must be ignored.
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'd2; mem_signed_i = 1'b0;
    mem_addr_i = 32'h5000; mem_wdata_i = 32'h0;
    tick;
    mem_req_i = 1'b0;
    #1;
    chk1("pre_abort_bus_req", bus_req_o, 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("abort_in_reset");
    tick;
    rst = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
    #1;
    chk_all_zero("abort_after");
    tick;
    bus_ack_i = 1'b0;
    #1;
    chk_all_zero("abort_no_retry");
    tick;

    // Back-to-back SW then LW, each acked after three wait cycles.
    do_access(1'b1, 2'd2, 1'b0, 32'h6004, 32'h1122_3344, 3, 32'h0);
    do_access(1'b0, 2'd3, 1'b1, 32'h6008, 32'h0, 3, 32'h8765_4321);

    // Misaligned halfword store and signed halfword load at offset 2.
    do_misaligned(1'b1, 2'd1, 32'h7003);
    do_access(1'b0, 2'd1, 1'b1, 32'h7002, 32'h0, 1, 32'h9ABC_0000);

    // Randomized accesses.
    repeat (80) begin
      size = 2'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr = addr - (addr % nbytes(size));
      if (m_aligned(size, addr)) begin
        delay = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 4);
        do_access(1'($urandom), size, 1'($urandom), addr, $urandom, delay, $urandom);
      end else begin
        do_misaligned(1'($urandom), size, addr);
      end
      if ($urandom_range(0, 2) == 0) begin
        #1;
        chk_all_zero("rand_idle");
        tick;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
